// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: function-select codes, FSM states,
// default datapath width and the shift-op classifier.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [3:0] {
        FS_ADD  = 4'd0,
        FS_SUB  = 4'd1,
        FS_AND  = 4'd2,
        FS_OR   = 4'd3,
        FS_XOR  = 4'd4,
        FS_NOTA = 4'd5,
        FS_NOTB = 4'd6,
        FS_SHL  = 4'd7,
        FS_SHR  = 4'd8,
        FS_ROL  = 4'd9,
        FS_ROR  = 4'd10,
        FS_ADC  = 4'd11,
        FS_SBC  = 4'd12,
        FS_ASR  = 4'd13,
        FS_CMP  = 4'd14,
        FS_PASS = 4'd15
    } fs_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic is_shift(input fs_e fs);
        return fs inside {FS_SHL, FS_SHR, FS_ROL, FS_ROR, FS_ASR};
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step: returns the value moved by one position and the
// bit that left the word (or crossed the end, for rotates).
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  fs_e              op,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

    always_comb begin
        shifted = value;
        bit_out = 1'b0;
        case (op)
            FS_SHL: begin
                shifted = {value[WIDTH-2:0], 1'b0};
                bit_out = value[WIDTH-1];
            end
            FS_SHR: begin
                shifted = {1'b0, value[WIDTH-1:1]};
                bit_out = value[0];
            end
            FS_ASR: begin
                shifted = {value[WIDTH-1], value[WIDTH-1:1]};
                bit_out = value[0];
            end
            FS_ROL: begin
                shifted = {value[WIDTH-2:0], value[WIDTH-1]};
                bit_out = value[WIDTH-1];
            end
            FS_ROR: begin
                shifted = {value[0], value[WIDTH-1:1]};
                bit_out = value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags, carry register for ADC/SBC and
// bit-serial shifts.
//   state    | meaning
//   ST_IDLE  | ready for a new operation
//   ST_SHIFT | bit-serial shift/rotate in progress
//   ST_HOLD  | result valid, waiting for out_ready
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       FS,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   SH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             busy
);

    state_e           state;
    fs_e              fs;
    fs_e              op_q;
    fs_e              step_op;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step_in;
    logic [WIDTH-1:0] step_val;
    logic             step_out;
    logic [SHW-1:0]   cnt;
    logic             cf;

    logic [WIDTH-1:0] bop;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_n, res_z, res_c, res_v;
    logic             accept, shift_go, use_alu, finish;

    assign fs        = fs_e'(FS);
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    assign accept   = (state == ST_IDLE) && in_valid;
    assign shift_go = is_shift(fs) && (SH != '0);
    assign use_alu  = (state == ST_IDLE) && !shift_go;
    // The first shift step happens on the accept edge, so SH=n gives latency n.
    assign finish   = (accept && (!shift_go || SH == SHW'(1)))
                    || (state == ST_SHIFT && cnt == SHW'(1));

    assign step_in = (state == ST_IDLE) ? A : work;
    assign step_op = (state == ST_IDLE) ? fs : op_q;

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .value   (step_in),
        .op      (step_op),
        .shifted (step_val),
        .bit_out (step_out)
    );

    always_comb begin
        bop = B;
        cin = 1'b0;
        case (fs)
            FS_SUB, FS_CMP: begin bop = ~B; cin = 1'b1; end
            FS_ADC:         cin = cf;
            FS_SBC:         begin bop = ~B; cin = cf; end
            default: ;
        endcase
        sum = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};

        res   = A;
        res_c = 1'b0;
        res_v = 1'b0;
        if (use_alu) begin
            case (fs)
                FS_ADD, FS_SUB, FS_ADC, FS_SBC, FS_CMP: begin
                    res   = (fs == FS_CMP) ? A : sum[WIDTH-1:0];
                    res_c = sum[WIDTH];
                    res_v = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                end
                FS_AND:  res = A & B;
                FS_OR:   res = A | B;
                FS_XOR:  res = A ^ B;
                FS_NOTA: res = ~A;
                FS_NOTB: res = ~B;
                default: res = A;
            endcase
        end else begin
            res   = step_val;
            res_c = step_out;
        end
        // CMP leaves A in F but reports the sign/zero of the difference.
        res_n = (use_alu && fs == FS_CMP) ? sum[WIDTH-1] : res[WIDTH-1];
        res_z = (use_alu && fs == FS_CMP) ? (sum[WIDTH-1:0] == '0) : (res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            F     <= '0;
            N     <= 1'b0;
            Z     <= 1'b0;
            C     <= 1'b0;
            V     <= 1'b0;
            cf    <= 1'b0;
            cnt   <= '0;
            work  <= '0;
            op_q  <= FS_ADD;
        end else if (finish) begin
            F     <= res;
            N     <= res_n;
            Z     <= res_z;
            C     <= res_c;
            V     <= res_v;
            cf    <= res_c;
            cnt   <= '0;
            state <= ST_HOLD;
        end else if (accept) begin
            work  <= step_val;
            cnt   <= SH - SHW'(1);
            op_q  <= fs;
            state <= ST_SHIFT;
        end else begin
            case (state)
                ST_SHIFT: begin
                    work <= step_val;
                    cnt  <= cnt - SHW'(1);
                end
                ST_HOLD:  if (out_ready) state <= ST_IDLE;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8 with hand-computed results,
// flags and latencies.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] FS = 4'd0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [2:0] SH = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] F;
    logic       N, Z, C, V;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .FS(FS), .A(A), .B(B), .SH(SH),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .N(N), .Z(Z), .C(C), .V(V), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [3:0] fs;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic [7:0] f;
        logic [3:0] nzcv;
        int         lat;
    } vec_t;

    vec_t vecs[16];

    // Present one op, return cycles from the presenting cycle to out_valid.
    task automatic issue(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sh, output int lat);
        @(negedge clk);
        FS = fs; A = a; B = b; SH = sh; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk) out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic [7:0] f_hold;
        logic seen;

        vecs[0]  = '{"add_ovf",  FS_ADD,  8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001, 1};
        vecs[1]  = '{"adc_cf0",  FS_ADC,  8'hFF, 8'h00, 3'd0, 8'hFF, 4'b1000, 1};
        vecs[2]  = '{"sub_eq",   FS_SUB,  8'h10, 8'h10, 3'd0, 8'h00, 4'b0110, 1};
        vecs[3]  = '{"sbc_cf1",  FS_SBC,  8'h05, 8'h01, 3'd0, 8'h04, 4'b0010, 1};
        vecs[4]  = '{"cmp_lt",   FS_CMP,  8'h01, 8'h02, 3'd0, 8'h01, 4'b1000, 1};
        vecs[5]  = '{"rol3",     FS_ROL,  8'h81, 8'h00, 3'd3, 8'h0C, 4'b0000, 3};
        vecs[6]  = '{"asr7",     FS_ASR,  8'h80, 8'h00, 3'd7, 8'hFF, 4'b1000, 7};
        vecs[7]  = '{"shl0",     FS_SHL,  8'h5A, 8'h00, 3'd0, 8'h5A, 4'b0000, 1};
        vecs[8]  = '{"and",      FS_AND,  8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000, 1};
        vecs[9]  = '{"xor",      FS_XOR,  8'hA5, 8'hFF, 3'd0, 8'h5A, 4'b0000, 1};
        vecs[10] = '{"shr1",     FS_SHR,  8'h81, 8'h00, 3'd1, 8'h40, 4'b0010, 1};
        vecs[11] = '{"ror1",     FS_ROR,  8'h01, 8'h00, 3'd1, 8'h80, 4'b1010, 1};
        vecs[12] = '{"notb",     FS_NOTB, 8'h12, 8'h00, 3'd0, 8'hFF, 4'b1000, 1};
        vecs[13] = '{"sub_brw",  FS_SUB,  8'h00, 8'h01, 3'd0, 8'hFF, 4'b1000, 1};
        vecs[14] = '{"add_wrap", FS_ADD,  8'h80, 8'h80, 3'd0, 8'h00, 4'b0111, 1};
        vecs[15] = '{"shl2",     FS_SHL,  8'h81, 8'h00, 3'd2, 8'h04, 4'b0000, 2};

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_f",      {24'd0, F}, 32'd0);
        chk("rst_flags",  {28'd0, N, Z, C, V}, 32'd0);
        chk("rst_status", {29'd0, out_valid, busy, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            issue(vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].sh, lat);
            chk({vecs[i].tag, "_lat"},  lat, vecs[i].lat);
            chk({vecs[i].tag, "_f"},    {24'd0, F}, {24'd0, vecs[i].f});
            chk({vecs[i].tag, "_nzcv"}, {28'd0, N, Z, C, V}, {28'd0, vecs[i].nzcv});
            consume(vecs[i].tag);
        end

        // Back-pressure: result held, new requests ignored.
        issue(FS_XOR, 8'h0F, 8'hFF, 3'd0, lat);
        f_hold = F;
        chk("bp_f", {24'd0, f_hold}, 32'hF0);
        @(negedge clk);
        FS = FS_ADD; A = 8'h01; B = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold", {22'd0, F, N, Z, C, V, out_valid, in_ready}, {22'd0, 8'hF0, 4'b1000, 2'b10});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        chk("bp_f_after", {24'd0, F}, 32'hF0);
        @(negedge clk) out_ready = 1'b0;

        // Reset in the middle of a shift; CF must also be cleared.
        issue(FS_SUB, 8'h10, 8'h10, 3'd0, lat);
        chk("pre_cf_c", {31'd0, C}, 32'd1);
        consume("pre_cf");
        @(negedge clk);
        FS = FS_SHR; A = 8'hFF; B = 8'h00; SH = 3'd6; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("mid_rst_state", {29'd0, busy, out_valid, in_ready}, 32'd0);
        chk("mid_rst_f", {24'd0, F}, 32'd0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("mid_no_result", {31'd0, seen}, 32'd0);
        issue(FS_ADC, 8'h00, 8'h00, 3'd0, lat);
        chk("post_adc_f",    {24'd0, F}, 32'd0);
        chk("post_adc_nzcv", {28'd0, N, Z, C, V}, 32'b0100);
        consume("post_adc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
